// File: rtl/obstacle_scheduler.sv
// Obstacle slot scheduler: spawns/scrolls/retires obstacles on step_tick, flags player collision.
// Latency: slot state 1 clk after step_tick; collision 1 clk after overlap. No backpressure: a spawn with no free slot waits for a later tick.
// Build option OBSTACLE_RANDOM_EN: LFSR-driven spawn y and spawn gap; otherwise FIXED_Y and GAP_MIN.
module obstacle_scheduler #(
    parameter int          NUM_SLOTS = 4,
    parameter int          X_START   = 127,
    parameter int          PLAYER_X  = 16,
    parameter int          OBS_H     = 8,
    parameter int          GAP_MIN   = 32,
    parameter int          FIXED_Y   = 0,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     obstacle_enable,
    input  logic                     step_tick,
    input  logic [6:0]               player_y,
    output logic [NUM_SLOTS-1:0]     slot_valid,
    output logic [7*NUM_SLOTS-1:0]   obs_x,
    output logic [7*NUM_SLOTS-1:0]   obs_y,
    output logic [2:0]               obs_count,
    output logic                     spawn_pulse,
    output logic                     collision_detected
);
    localparam int GW = $clog2(GAP_MIN + 16) + 1;

    logic [15:0]          lfsr;
    logic [15:0]          lfsr_next;
    logic [GW-1:0]        gap_cnt;
    logic [GW-1:0]        gap_reload;
    logic [NUM_SLOTS-1:0] valid_q;
    logic [6:0]           x_q [NUM_SLOTS];
    logic [6:0]           y_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] spawn_oh;
    logic                 spawn_ok;
    logic                 spawn_req;
    logic [6:0]           spawn_y;
    logic                 hit;
    logic                 spawn_pulse_q;
    logic                 collision_q;
    logic                 unused_lfsr;

    assign lfsr_next   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign unused_lfsr = ^lfsr;

`ifdef OBSTACLE_RANDOM_EN
    assign spawn_y    = {1'b0, lfsr[5:0]};
    assign gap_reload = GW'(GAP_MIN) + GW'(lfsr[11:8]);
`else
    assign spawn_y    = 7'(FIXED_Y);
    assign gap_reload = GW'(GAP_MIN);
`endif

    assign spawn_req = (gap_cnt <= GW'(1));

    // Only slots free before this tick are candidates, so a retiring slot is never reused on the same tick.
    always_comb begin
        logic found;
        found    = 1'b0;
        spawn_oh = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!valid_q[i] && !found) begin
                spawn_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
        spawn_ok = spawn_req && found;
    end

    always_comb begin
        hit       = 1'b0;
        obs_count = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            obs_count = obs_count + 3'(valid_q[i]);
            if (valid_q[i] && (x_q[i] == 7'(PLAYER_X)) &&
                ({1'b0, y_q[i]} <= {1'b0, player_y}) &&
                ({1'b0, player_y} <= ({1'b0, y_q[i]} + 8'(OBS_H - 1))))
                hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr          <= SEED;
            gap_cnt       <= GW'(GAP_MIN);
            valid_q       <= '0;
            spawn_pulse_q <= 1'b0;
            collision_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= 7'd0;
                y_q[i] <= 7'd0;
            end
        end else begin
            lfsr <= lfsr_next;
            if (!obstacle_enable) begin
                gap_cnt       <= GW'(GAP_MIN);
                valid_q       <= '0;
                spawn_pulse_q <= 1'b0;
                collision_q   <= 1'b0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    x_q[i] <= 7'd0;
                    y_q[i] <= 7'd0;
                end
            end else begin
                spawn_pulse_q <= 1'b0;
                collision_q   <= collision_q | hit;
                if (step_tick) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (valid_q[i]) begin
                            if (x_q[i] == 7'd0)
                                valid_q[i] <= 1'b0;
                            else
                                x_q[i] <= x_q[i] - 7'd1;
                        end else if (spawn_ok && spawn_oh[i]) begin
                            valid_q[i] <= 1'b1;
                            x_q[i]     <= 7'(X_START);
                            y_q[i]     <= spawn_y;
                        end
                    end
                    if (spawn_ok) begin
                        gap_cnt       <= gap_reload;
                        spawn_pulse_q <= 1'b1;
                    end else if (!spawn_req) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign obs_x[7*g +: 7] = x_q[g];
        assign obs_y[7*g +: 7] = y_q[g];
    end

    assign slot_valid         = valid_q;
    assign spawn_pulse        = spawn_pulse_q;
    assign collision_detected = collision_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomised-timing bench for obstacle_scheduler with a tick-indexed reference model and spawn scoreboard.
module tb_obstacle_scheduler;
    localparam int NS = 4;
    localparam int XS = 127;
    localparam int PX = 16;
    localparam int OH = 8;
    localparam int GM = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              st = 1'b0;
    logic [6:0]        py = 7'd0;
    logic [NS-1:0]     slot_valid;
    logic [7*NS-1:0]   obs_x;
    logic [7*NS-1:0]   obs_y;
    logic [2:0]        obs_count;
    logic              spawn_pulse;
    logic              collision_detected;

    obstacle_scheduler #(.NUM_SLOTS(NS), .X_START(XS), .PLAYER_X(PX), .OBS_H(OH),
                         .GAP_MIN(GM), .FIXED_Y(0), .SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .obstacle_enable(en), .step_tick(st), .player_y(py),
        .slot_valid(slot_valid), .obs_x(obs_x), .obs_y(obs_y), .obs_count(obs_count),
        .spawn_pulse(spawn_pulse), .collision_detected(collision_detected)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int slot; int tick; } exp_t;
    exp_t q[$];

    // Model: slot i was spawned on tick s[i]; its x after tick t is XS-(t-s[i]); it disappears on tick s[i]+XS+1.
    int  used [NS];
    int  s    [NS];
    int  t;
    int  last;
    bit  sticky;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (tick %0d, time %0t)", nm, act, req, t, $time);
        end
    endtask

    function automatic bit alive(int i, int tt);
        return (used[i] != 0) && (tt >= s[i]) && (tt <= s[i] + XS);
    endfunction

    function automatic bit model_hit();
        bit h = 1'b0;
        for (int i = 0; i < NS; i++)
            if (alive(i, t) && (XS - (t - s[i])) == PX && int'(py) >= 0 && int'(py) <= OH - 1)
                h = 1'b1;
        return h;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            used[i] = 0;
            s[i]    = 0;
        end
        t      = 0;
        last   = 0;
        sticky = 1'b0;
    endtask

    task automatic compare_state();
        int cnt = 0;
        for (int i = 0; i < NS; i++) begin
            check("slot_valid", int'(slot_valid[i]), int'(alive(i, t)));
            if (alive(i, t)) begin
                cnt++;
                check("obs_x", int'(obs_x[7*i +: 7]), XS - (t - s[i]));
                check("obs_y", int'(obs_y[7*i +: 7]), 0);
            end
        end
        check("obs_count", int'(obs_count), cnt);
    endtask

    task automatic do_tick();
        @(negedge clk);
        st = 1'b1;
        if (en) begin
            int pick = -1;
            t++;
            for (int i = NS - 1; i >= 0; i--)
                if (!alive(i, t - 1)) pick = i;
            if ((t - last) >= GM && pick >= 0) begin
                used[pick] = 1;
                s[pick]    = t;
                last       = t;
                q.push_back('{pick, t});
            end
        end
        @(negedge clk);
        st = 1'b0;
        compare_state();
        check("collision_lag", int'(collision_detected), int'(sticky));
        if (en) sticky = sticky | model_hit();
        @(negedge clk);
        check("collision", int'(collision_detected), int'(sticky));
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic set_py(input logic [6:0] v);
        @(negedge clk);
        py = v;
        @(negedge clk);
        @(negedge clk);
        if (en) sticky = sticky | model_hit();
        check("collision_py", int'(collision_detected), int'(sticky));
    endtask

    task automatic set_en(input logic v);
        @(negedge clk);
        en = v;
        if (!v) model_clear();
        @(negedge clk);
        if (!v) begin
            check("dis_valid", int'(slot_valid), 0);
            check("dis_count", int'(obs_count), 0);
            check("dis_collision", int'(collision_detected), 0);
            check("dis_spawn", int'(spawn_pulse), 0);
        end
    endtask

    // Scoreboard monitor: every spawn_pulse consumes one expected spawn.
    always @(negedge clk) begin
        if (rst_n && spawn_pulse) begin
            if (q.size() == 0) begin
                check("unexpected_spawn", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("spawn_tick", t, e.tick);
                check("spawn_slot_valid", int'(slot_valid[e.slot]), 1);
                check("spawn_x", int'(obs_x[7*e.slot +: 7]), XS);
                check("spawn_y", int'(obs_y[7*e.slot +: 7]), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        py = 7'd20;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(slot_valid), 0);
        check("rst_count", int'(obs_count), 0);
        check("rst_collision", int'(collision_detected), 0);
        check("rst_spawn", int'(spawn_pulse), 0);
        rst_n = 1'b1;

        repeat (5) do_tick();

        set_en(1'b1);
        repeat (150) do_tick();
        check("no_hit_py20", int'(collision_detected), 0);
        set_en(1'b0);

        set_en(1'b1);
        set_py(7'd4);
        repeat (170) do_tick();
        check("hit_py4_held", int'(collision_detected), 1);
        set_en(1'b0);

        set_en(1'b1);
        for (int k = 0; k < 4; k++) begin
            set_py(7'($urandom_range(0, 40)));
            repeat (25) do_tick();
        end
        set_en(1'b0);
        set_en(1'b1);
        repeat (40) do_tick();

        @(negedge clk);
        st    = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(slot_valid), 0);
        check("arst_spawn", int'(spawn_pulse), 0);
        check("arst_collision", int'(collision_detected), 0);
        @(negedge clk);
        st    = 1'b0;
        rst_n = 1'b1;
        model_clear();
        set_py(7'($urandom_range(0, 10)));
        repeat (40) do_tick();

        repeat (3) @(negedge clk);
        check("pending_spawns", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
